// File: rtl/relu_act.sv
// Two-stage activation pipeline: per-lane activation (stage 1), then rounding
// requantisation with saturation into the output register (stage 2).
`timescale 1ns/1ps
module relu_act #(
  parameter int IMAGE_WIDTH  = 6,
  parameter int IMAGE_HEIGHT = 8,
  parameter int CHANNELS     = 128,
  parameter int DATA_BITS    = 32,
  parameter int OUT_BITS     = 16,
  parameter int SHIFT        = 8,
  parameter int LEAKY_SHIFT  = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  data_in,
  input  logic [1:0]                          mode,
  input  logic [DATA_BITS-1:0]                clip_max,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS-1:0][OUT_BITS-1:0]   data_out,
  output logic                                out_last,
  output logic                                frame_done,
  output logic                                sat_flag,
  input  logic                                sat_clr
);

  localparam int unsigned PIX_TOTAL = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_TOTAL - 1);

  // Half-LSB rounding constant; collapses to zero when SHIFT is 0.
  localparam logic signed [DATA_BITS:0] RND     = ((DATA_BITS+1)'(1) << SHIFT) >> 1;
  localparam logic signed [DATA_BITS:0] SAT_MAX = ((DATA_BITS+1)'(1) << (OUT_BITS-1)) - (DATA_BITS+1)'(1);
  localparam logic signed [DATA_BITS:0] SAT_MIN = ~SAT_MAX;

  function automatic logic [DATA_BITS-1:0] act_lane(
    input logic signed [DATA_BITS-1:0] x,
    input logic        [1:0]           m,
    input logic        [DATA_BITS-1:0] clip
  );
    logic [DATA_BITS-1:0] y;
    logic                 is_neg;
    logic                 is_zero;
    is_neg  = x[DATA_BITS-1];
    is_zero = (x == '0);
    y       = x;
    case (m)
      2'd1: if (is_neg) y = '0;
      2'd2: begin
        // clip_max is an unsigned ceiling, so compare the positive x unsigned
        if (is_neg || is_zero)      y = '0;
        else if ($unsigned(x) > clip) y = clip;
      end
      2'd3: if (is_neg) y = x >>> LEAKY_SHIFT;
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [OUT_BITS:0] requant(input logic [DATA_BITS-1:0] y);
    logic signed [DATA_BITS:0] ext;
    logic signed [DATA_BITS:0] z;
    ext = signed'({y[DATA_BITS-1], y});
    z   = (ext + RND) >>> SHIFT;
    if (z > SAT_MAX)      return {1'b1, SAT_MAX[OUT_BITS-1:0]};
    else if (z < SAT_MIN) return {1'b1, SAT_MIN[OUT_BITS-1:0]};
    else                  return {1'b0, z[OUT_BITS-1:0]};
  endfunction

  logic                               r_s1_valid;
  logic                               r_s1_last;
  logic [CHANNELS-1:0][DATA_BITS-1:0] r_s1_y;
  logic [CNT_W-1:0]                   r_pix_cnt;
  logic                               r_out_valid;
  logic                               r_out_last;
  logic [CHANNELS-1:0][OUT_BITS-1:0]  r_data_out;
  logic                               r_sat_evt;
  logic                               r_sat_flag;
  logic                               r_frame_done;

  logic                               w_s2_load;
  logic                               w_s1_load;
  logic                               w_accept;
  logic                               w_is_last;
  logic [CHANNELS-1:0][DATA_BITS-1:0] w_s1_y;
  logic [CHANNELS-1:0][OUT_BITS-1:0]  w_s2_z;
  logic                               w_sat_any;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && w_s1_load;
  assign w_is_last = (r_pix_cnt == PIX_LAST);

  always_comb begin
    w_s1_y    = '0;
    w_s2_z    = '0;
    w_sat_any = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      logic [OUT_BITS:0] w_rq;
      w_s1_y[i] = act_lane(data_in[i], mode, clip_max);
      w_rq      = requant(r_s1_y[i]);
      w_s2_z[i] = w_rq[OUT_BITS-1:0];
      w_sat_any = w_sat_any | w_rq[OUT_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_pix_cnt  <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        r_s1_last  <= in_valid && w_is_last;
      end
      if (w_accept) r_pix_cnt <= w_is_last ? '0 : r_pix_cnt + CNT_W'(1);
    end
  end

  // Stage-1 data carries no reset: it is only observed behind r_s1_valid.
  always_ff @(posedge clk) begin
    if (w_accept) r_s1_y <= w_s1_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_data_out   <= '0;
      r_sat_evt    <= 1'b0;
      r_sat_flag   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
        r_out_last  <= r_s1_last;
        if (r_s1_valid) r_data_out <= w_s2_z;
      end
      r_sat_evt    <= w_s2_load && r_s1_valid && w_sat_any;
      r_frame_done <= r_out_valid && out_ready && r_out_last;
      // A fresh saturation event outranks a coincident clear.
      if (r_sat_evt)    r_sat_flag <= 1'b1;
      else if (sat_clr) r_sat_flag <= 1'b0;
    end
  end

  assign in_ready   = w_s1_load;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign data_out   = r_data_out;
  assign frame_done = r_frame_done;
  assign sat_flag   = r_sat_flag;

endmodule

// File: doc/relu_act.md
RELU_ACT -- requirements
Module: relu_act

Interface
REQ-001 The block SHALL have parameter IMAGE_WIDTH, default 6, meaning pixels per row.
REQ-002 The block SHALL have parameter IMAGE_HEIGHT, default 8, meaning rows per frame.
REQ-003 The block SHALL have parameter CHANNELS, default 128, meaning lanes processed per beat.
REQ-004 The block SHALL have parameter DATA_BITS, default 32, meaning signed input lane width.
REQ-005 The block SHALL have parameter OUT_BITS, default 16, meaning signed output lane width, with OUT_BITS <= DATA_BITS.
REQ-006 The block SHALL have parameter SHIFT, default 8, meaning the requantisation right-shift, 0 to DATA_BITS-1.
REQ-007 The block SHALL have parameter LEAKY_SHIFT, default 3, meaning the negative-slope arithmetic shift.
REQ-008 The block SHALL have these ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-009 The block SHALL have these ports: in_valid  in  1  input beat valid; in_ready  out  1  beat accepted when in_valid && in_ready.
REQ-010 The block SHALL have port data_in  in  CHANNELS x DATA_BITS  signed lanes.
REQ-011 The block SHALL have these ports: mode  in  2  activation select (0 bypass, 1 ReLU, 2 clipped ReLU, 3 leaky); clip_max  in  DATA_BITS  clip ceiling for mode 2, treated as non-negative.
REQ-012 The block SHALL have these ports: out_valid  out  1; out_ready  in  1; data_out  out  CHANNELS x OUT_BITS  signed lanes.
REQ-013 The block SHALL have these ports: out_last  out  1  marks the final pixel of a frame; frame_done  out  1  one-cycle pulse.
REQ-014 The block SHALL have these ports: sat_flag  out  1  sticky saturation indicator; sat_clr  in  1  synchronous clear for sat_flag.

Function
REQ-015 The block SHALL sample mode and clip_max with each accepted beat and hold them with that beat through the pipeline; mid-stream changes SHALL affect only later beats.
REQ-016 Stage 1 SHALL compute per lane:
- mode 0: y = x
- mode 1: y = x > 0 ? x : 0
- mode 2: y = x <= 0 ? 0 : min(x, clip_max)
- mode 3: y = x >= 0 ? x : x >>> LEAKY_SHIFT (arithmetic shift)
REQ-017 Stage 2 SHALL compute z = (y + 2^(SHIFT-1)) >>> SHIFT when SHIFT > 0, or z = y when SHIFT = 0, using DATA_BITS+1-bit intermediate arithmetic so rounding never overflows.
REQ-018 Stage 2 SHALL saturate z to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
REQ-019 Any lane saturating in a beat that reaches the output register SHALL set sat_flag on the following clock.
REQ-020 sat_flag SHALL stay set until sat_clr is high; if sat_clr and a new saturation coincide, sat_flag SHALL remain set.
REQ-021 The pipeline SHALL have two register stages (s1, s2 = output), each with its own valid bit.
REQ-022 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-023 A beat SHALL transfer out when out_valid && out_ready.
REQ-024 s2 SHALL load when !out_valid || out_ready, and s1 SHALL load when !s1_valid || s2 loads.
REQ-025 in_ready SHALL equal the s1 load condition, be combinational from out_ready and the valid bits, and never depend on in_valid.
REQ-026 Under stall, data_out, out_valid and out_last SHALL hold stable; no beat SHALL be dropped or duplicated.
REQ-027 A pixel counter SHALL count accepted beats 0 .. IMAGE_WIDTH*IMAGE_HEIGHT-1, tagging the beat whose index is the maximum as last and wrapping to 0 on the next acceptance.
REQ-028 out_last SHALL accompany the tagged beat at the output.
REQ-029 frame_done SHALL pulse high for one cycle in the clock after the last-tagged beat transfers out.
REQ-030 Sustained throughput SHALL be one beat per cycle with in_valid and out_ready both held high.

Reset
REQ-031 On rst_n low, the block SHALL asynchronously clear out_valid, s1 valid, data_out (all lanes), out_last, frame_done, sat_flag and the pixel counter to 0.
REQ-032 in_ready SHALL read 1 during and after reset.
REQ-033 Reset mid-frame SHALL discard in-flight beats, and the first beat after reset SHALL be pixel 0.

Verification
REQ-034 Test: mode 1, SHIFT 0, OUT_BITS 32, lanes {5, -7, 0, 0x7FFFFFFF} -> {5, 0, 0, 0x7FFFFFFF} two cycles later.
REQ-035 Test: mode 2, clip_max 100, SHIFT 0, lanes {-1, 50, 100, 101} -> {0, 50, 100, 100}.
REQ-036 Test: mode 3, LEAKY_SHIFT 3, SHIFT 0, lane -64 -> -8; lane -1 -> -1.
REQ-037 Test: defaults (SHIFT 8, OUT_BITS 16), lane 384 -> 2 (rounding of 1.5); lane 0x01000000 -> 32767, then sat_flag=1 next cycle; sat_clr -> sat_flag=0.
REQ-038 Test: stream 48 beats with out_ready toggling pseudo-randomly -> all 48 emerge in order, out_last only on beat 47, one frame_done pulse, and the 49th beat indexed as pixel 0.
REQ-039 Test: assert rst_n low with 2 beats in flight -> out_valid=0 immediately, no stale beats after release, and pixel counter restarts at 0.
